// File: rtl/chinpo_mem_responder.sv
// CHINPO memory responder: services level-held MemRead/MemWrite requests against a synchronous
// single-port RAM with WAIT_CYCLES wait states. Define CHINPO_MEM_WBUF_EN for a one-entry posted write buffer.
module chinpo_mem_responder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              MemError,
    output logic              WbufBusy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, RDATA, RELEASE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
`ifdef CHINPO_MEM_WBUF_EN
    localparam bit WBUF_ON = 1'b1;
`else
    localparam bit WBUF_ON = 1'b0;
`endif

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_write;
    logic [DATA_W-1:0] read_data_q;
    logic              ready_q, ready_nxt;
    logic              error_q, error_nxt;
    logic              accept;
    logic              strobes_low;
    logic              posted;
    logic              rel_pend;

    assign strobes_low = !MemRead && !MemWrite;

    // NOTE: every variable gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        ready_nxt = 1'b0;
        error_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (MemRead && MemWrite) begin
                    error_nxt = 1'b1;
                    state_nxt = RELEASE;
                end else if (MemRead || MemWrite) begin
                    accept    = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_INIT != 4'd0) ? WAIT : ACCESS;
                    if (WBUF_ON && MemWrite) ready_nxt = 1'b1;
                end
            end
            WAIT: begin
                // A posted write belongs to the responder now; only a live request can be abandoned.
                if (strobes_low && !posted) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!lat_write) begin
                    state_nxt = RDATA;
                end else if (posted) begin
                    state_nxt = (rel_pend && !strobes_low) ? RELEASE : IDLE;
                end else begin
                    ready_nxt = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RDATA: begin
                ready_nxt = 1'b1;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (strobes_low) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= ready_nxt;
            error_q <= error_nxt;
            if (accept) begin
                lat_addr  <= Addr;
                lat_wdata <= WriteData;
                lat_write <= MemWrite;
            end
            if (state == RDATA) read_data_q <= ram_rdata;
        end
    end

`ifdef CHINPO_MEM_WBUF_EN
    logic wbuf_busy_q;
    logic rel_pend_q;

    // rel_pend_q remembers that the requester has not yet dropped the strobe of a posted write.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wbuf_busy_q <= 1'b0;
            rel_pend_q  <= 1'b0;
        end else if (accept && MemWrite) begin
            wbuf_busy_q <= 1'b1;
            rel_pend_q  <= 1'b1;
        end else begin
            if (state == ACCESS) wbuf_busy_q <= 1'b0;
            if (strobes_low)     rel_pend_q  <= 1'b0;
        end
    end

    assign posted   = wbuf_busy_q;
    assign rel_pend = rel_pend_q;
    assign WbufBusy = wbuf_busy_q;
`else
    assign posted   = 1'b0;
    assign rel_pend = 1'b0;
    assign WbufBusy = 1'b0;
`endif

    assign ReadData  = read_data_q;
    assign MemReady  = ready_q;
    assign MemError  = error_q;
    assign ram_en    = (state == ACCESS);
    assign ram_we    = (state == ACCESS) && lat_write;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;

endmodule

// File: tb/tb_chinpo_mem_responder.sv
// Scoreboard bench for chinpo_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
// Stimulus pushes expected RAM/MemReady/MemError events; a negedge monitor pops and compares them.
module tb_chinpo_mem_responder;

    typedef enum logic [1:0] {EV_RAM, EV_READY, EV_ERR} ev_t;
    typedef struct {
        ev_t         kind;
        int          cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic             CLK = 1'b0;
    logic             Reset;
    logic [1:0]       mem_read, mem_write, mem_ready, mem_error, wbuf_busy, ram_en, ram_we;
    logic [1:0][15:0] addr, wdata, read_data, ram_addr, ram_wdata, ram_rdata;
    logic [15:0]      ram [2][256];
    exp_t             expq [2][$];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    chinpo_mem_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) u_dut_w2 (
        .CLK(CLK), .Reset(Reset), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Addr(addr[0]), .WriteData(wdata[0]), .ReadData(read_data[0]), .MemReady(mem_ready[0]),
        .MemError(mem_error[0]), .WbufBusy(wbuf_busy[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
        .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    chinpo_mem_responder #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut_w0 (
        .CLK(CLK), .Reset(Reset), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Addr(addr[1]), .WriteData(wdata[1]), .ReadData(read_data[1]), .MemReady(mem_ready[1]),
        .MemError(mem_error[1]), .WbufBusy(wbuf_busy[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
        .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Behavioural synchronous RAMs: read data appears the cycle after the enable cycle.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_en[i] === 1'b1) begin
                if (ram_we[i]) ram[i][ram_addr[i][7:0]] <= ram_wdata[i];
                else           ram_rdata[i] <= ram[i][ram_addr[i][7:0]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int i, input ev_t k, input int c, input logic we,
                        input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.kind = k; e.cyc = c; e.we = we; e.addr = a; e.data = d;
        expq[i].push_back(e);
    endtask

    task automatic observe(input int i, input ev_t k, input logic we,
                           input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        bit   ok;
        checks++;
        if (expq[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s inst=%0d cycle=%0d: got we=%0b addr=%h data=%h, required no event",
                     k.name(), i, cyc, we, a, d);
            return;
        end
        e  = expq[i].pop_front();
        ok = (e.kind == k) && (e.cyc == cyc);
        if (k == EV_RAM)   ok = ok && (we === e.we) && (a === e.addr) && (!e.we || d === e.data);
        if (k == EV_READY) ok = ok && (d === e.data);
        if (!ok) begin
            errors++;
            $display("FAIL event inst=%0d: got %s cycle=%0d we=%0b addr=%h data=%h, required %s cycle=%0d we=%0b addr=%h data=%h",
                     i, k.name(), cyc, we, a, d, e.kind.name(), e.cyc, e.we, e.addr, e.data);
        end
    endtask

    // Monitor: every visible DUT event is matched against the head of that instance's queue.
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (ram_en[i] === 1'b1)    observe(i, EV_RAM, ram_we[i], ram_addr[i], ram_wdata[i]);
            if (mem_ready[i] === 1'b1) observe(i, EV_READY, 1'b0, 16'h0000, read_data[i]);
            if (mem_error[i] === 1'b1) observe(i, EV_ERR, 1'b0, 16'h0000, 16'h0000);
        end
    end

    // Requester model: hold strobes until MemReady/MemError, hold 'hold' more cycles, then one low cycle.
    task automatic issue(input int i, input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input int hold);
        bit seen = 1'b0;
        mem_read[i]  = rd;
        mem_write[i] = wr;
        addr[i]      = a;
        wdata[i]     = d;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (mem_ready[i] === 1'b1 || mem_error[i] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL handshake_timeout inst=%0d: got no MemReady/MemError in 40 cycles, required one", i);
        end
        repeat (1 + hold) @(negedge CLK);
        mem_read[i]  = 1'b0;
        mem_write[i] = 1'b0;
        @(negedge CLK);
`ifdef CHINPO_MEM_WBUF_EN
        for (int k = 0; k < 40 && wbuf_busy[i] === 1'b1; k++) @(negedge CLK);
`endif
    endtask

    task automatic exp_write(input int i, input int c0, input int w, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] rd_prev);
`ifdef CHINPO_MEM_WBUF_EN
        if (w == 0) begin
            push(i, EV_RAM, c0 + 1, 1'b1, a, d);
            push(i, EV_READY, c0 + 1, 1'b0, 16'h0000, rd_prev);
        end else begin
            push(i, EV_READY, c0 + 1, 1'b0, 16'h0000, rd_prev);
            push(i, EV_RAM, c0 + w + 1, 1'b1, a, d);
        end
`else
        push(i, EV_RAM, c0 + w + 1, 1'b1, a, d);
        push(i, EV_READY, c0 + w + 2, 1'b0, 16'h0000, rd_prev);
`endif
    endtask

    task automatic do_write(input int i, input int w, input logic [15:0] a, input logic [15:0] d,
                            input logic [15:0] rd_prev, input int hold);
        exp_write(i, cyc, w, a, d, rd_prev);
        issue(i, 1'b0, 1'b1, a, d, hold);
    endtask

    task automatic do_read(input int i, input int w, input logic [15:0] a, input logic [15:0] d);
        push(i, EV_RAM, cyc + w + 1, 1'b0, a, 16'h0000);
        push(i, EV_READY, cyc + w + 3, 1'b0, 16'h0000, d);
        issue(i, 1'b1, 1'b0, a, 16'h0000, 0);
    endtask

    initial begin
        int c0;
        Reset     = 1'b0;
        mem_read  = '0;
        mem_write = '0;
        addr      = '0;
        wdata     = '0;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ReadData_%0d", i),  32'(read_data[i]), 32'h0);
            check($sformatf("reset_MemReady_%0d", i),  32'(mem_ready[i]), 32'h0);
            check($sformatf("reset_MemError_%0d", i),  32'(mem_error[i]), 32'h0);
            check($sformatf("reset_WbufBusy_%0d", i),  32'(wbuf_busy[i]), 32'h0);
            check($sformatf("reset_ram_en_%0d", i),    32'(ram_en[i]), 32'h0);
            check($sformatf("reset_ram_we_%0d", i),    32'(ram_we[i]), 32'h0);
            check($sformatf("reset_ram_addr_%0d", i),  32'(ram_addr[i]), 32'h0);
            check($sformatf("reset_ram_wdata_%0d", i), 32'(ram_wdata[i]), 32'h0);
        end
        Reset = 1'b1;

        // W=2: write, read back, both-strobe error, recovery read.
        do_write(0, 2, 16'h0010, 16'hBEEF, 16'h0000, 0);
        do_read(0, 2, 16'h0010, 16'hBEEF);
        push(0, EV_ERR, cyc + 1, 1'b0, 16'h0000, 16'h0000);
        issue(0, 1'b1, 1'b1, 16'h0010, 16'h0000, 0);
        do_read(0, 2, 16'h0010, 16'hBEEF);

        // Strobe dropped in the first WAIT cycle: nothing may reach the RAM or the requester.
        mem_read[0] = 1'b1;
        addr[0]     = 16'h0010;
        @(negedge CLK);
        mem_read[0] = 1'b0;
        repeat (6) @(negedge CLK);

        // Strobe held 5 cycles past completion: exactly one RAM access.
        do_write(0, 2, 16'h0020, 16'h5A5A, 16'hBEEF, 5);
        do_read(0, 2, 16'h0020, 16'h5A5A);
        do_write(0, 2, 16'h0030, 16'h7777, 16'h5A5A, 0);

        // W=0 instance.
        do_write(1, 0, 16'h0000, 16'h1234, 16'h0000, 0);
        do_read(1, 0, 16'h0000, 16'h1234);
        do_write(1, 0, 16'h0002, 16'hCAFE, 16'h1234, 0);
        do_read(1, 0, 16'h0002, 16'hCAFE);

        // Reset in the second WAIT cycle of a write to 0x0030 discards it.
        c0 = cyc;
`ifdef CHINPO_MEM_WBUF_EN
        push(0, EV_READY, c0 + 1, 1'b0, 16'h0000, 16'h5A5A);
`endif
        mem_write[0] = 1'b1;
        addr[0]      = 16'h0030;
        wdata[0]     = 16'h1111;
        repeat (2) @(negedge CLK);
        Reset        = 1'b0;
        mem_write[0] = 1'b0;
        @(negedge CLK);
        check("rst_wait_ReadData",  32'(read_data[0]), 32'h0);
        check("rst_wait_MemReady",  32'(mem_ready[0]), 32'h0);
        check("rst_wait_MemError",  32'(mem_error[0]), 32'h0);
        check("rst_wait_WbufBusy",  32'(wbuf_busy[0]), 32'h0);
        check("rst_wait_ram_en",    32'(ram_en[0]), 32'h0);
        check("rst_wait_ram_we",    32'(ram_we[0]), 32'h0);
        check("rst_wait_ram_addr",  32'(ram_addr[0]), 32'h0);
        check("rst_wait_ram_wdata", 32'(ram_wdata[0]), 32'h0);
        Reset = 1'b1;
        do_read(0, 2, 16'h0030, 16'h7777);

`ifdef CHINPO_MEM_WBUF_EN
        // Posted write followed by a read raised during the drain; the read waits for the write's ACCESS.
        c0 = cyc;
        push(0, EV_READY, c0 + 1, 1'b0, 16'h0000, 16'h7777);
        push(0, EV_RAM,   c0 + 3, 1'b1, 16'h0040, 16'hABCD);
        push(0, EV_RAM,   c0 + 7, 1'b0, 16'h0040, 16'h0000);
        push(0, EV_READY, c0 + 9, 1'b0, 16'h0000, 16'hABCD);
        mem_write[0] = 1'b1;
        addr[0]      = 16'h0040;
        wdata[0]     = 16'hABCD;
        @(negedge CLK);
        check("wbuf_busy_set", 32'(wbuf_busy[0]), 32'h1);
        @(negedge CLK);
        mem_write[0] = 1'b0;
        @(negedge CLK);
        issue(0, 1'b1, 1'b0, 16'h0040, 16'h0000, 0);
        check("wbuf_busy_clear", 32'(wbuf_busy[0]), 32'h0);
`endif

        repeat (6) @(negedge CLK);
        for (int i = 0; i < 2; i++)
            check($sformatf("queue_drained_%0d", i), 32'(expq[i].size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
